// File: rtl/zx_io_port_sync.sv
`default_nettype none
// ============================================================================
// Module      : zx_io_port_sync
// Description : Clocked front end for the cartridge bank logic. It
//               synchronises the raw Z80 I/O pins, glitch-filters them and
//               decodes accesses to port 0x7F (A7=0, IORQ low, M1 high). For
//               each accepted I/O cycle it emits exactly one single-clock
//               strobe, which replaces the raw IORQ|A7 edge clock used by the
//               bank counter / self-lock stage.
// Ports       : clk          system clock
//               reset_n      asynchronous active-low reset
//               iorq_n, rd_n, wr_n, m1_n, A7, D[7:0]
//                            raw Z80 bus pins (unsynchronised)
//               lock         from the self-lock stage; 1 suppresses strobes
//               page_up_stb  1-clk pulse per accepted access (read or write)
//               io_rd_stb    1-clk pulse, accepted access was a read
//               io_wr_stb    1-clk pulse, accepted access was a write
//               wr_data      D captured at the last accepted write
//               busy         FSM is not idle
//               glitch_cnt   saturating count of aborted qualifications
// Revision    : 1.0  initial release
// ============================================================================
module zx_io_port_sync #(
    parameter int SYNC_STAGES   = 2,   // legal 2..4
    parameter int FILTER_CYCLES = 2    // legal 1..15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       iorq_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic       m1_n,
    input  logic       A7,
    input  logic [7:0] D,
    input  logic       lock,
    output logic       page_up_stb,
    output logic       io_rd_stb,
    output logic       io_wr_stb,
    output logic [7:0] wr_data,
    output logic       busy,
    output logic [7:0] glitch_cnt
);

    localparam logic [3:0] c_FILTER = 4'(FILTER_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_QUAL   = 2'd1,
        S_ACTIVE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers. Control pins idle high, so their flops reset
    // to 1; the data bus resets to 0. Stage 0 takes the raw pin, the
    // last stage is the synchronised value.
    // ------------------------------------------------------------------
    logic [4:0]                    w_ctrl_raw;
    logic [SYNC_STAGES-1:0][4:0]   r_ctrl_pipe;
    logic [SYNC_STAGES-1:0][7:0]   r_data_pipe;

    assign w_ctrl_raw = {A7, m1_n, wr_n, rd_n, iorq_n};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ctrl_pipe <= '1;
            r_data_pipe <= '0;
        end else begin
            r_ctrl_pipe <= {r_ctrl_pipe[SYNC_STAGES-2:0], w_ctrl_raw};
            r_data_pipe <= {r_data_pipe[SYNC_STAGES-2:0], D};
        end
    end

    logic       w_iorq_s;
    logic       w_rd_s;
    logic       w_wr_s;
    logic       w_m1_s;
    logic       w_a7_s;
    logic [7:0] w_d_s;
    logic       w_q;

    assign w_iorq_s = r_ctrl_pipe[SYNC_STAGES-1][0];
    assign w_rd_s   = r_ctrl_pipe[SYNC_STAGES-1][1];
    assign w_wr_s   = r_ctrl_pipe[SYNC_STAGES-1][2];
    assign w_m1_s   = r_ctrl_pipe[SYNC_STAGES-1][3];
    assign w_a7_s   = r_ctrl_pipe[SYNC_STAGES-1][4];
    assign w_d_s    = r_data_pipe[SYNC_STAGES-1];

    // Qualifier: port 0x7F access with RD or WR low. M1 low alongside
    // IORQ is an interrupt acknowledge and never qualifies.
    assign w_q = !w_iorq_s && !w_a7_s && w_m1_s && (!w_rd_s || !w_wr_s);

    // ------------------------------------------------------------------
    // Filter / cycle-tracking FSM
    // ------------------------------------------------------------------
    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_filt;
    logic [3:0] w_filt_nxt;
    logic       w_accept;
    logic       w_glitch;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_filt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_filt  <= w_filt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_filt_nxt  = r_filt;
        w_accept    = 1'b0;
        w_glitch    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_filt_nxt = '0;
                if (w_q) begin
                    if (c_FILTER == 4'd1) begin
                        w_accept    = 1'b1;
                        w_state_nxt = S_ACTIVE;
                    end else begin
                        w_filt_nxt  = 4'd1;
                        w_state_nxt = S_QUAL;
                    end
                end
            end
            S_QUAL: begin
                if (!w_q) begin
                    w_glitch    = 1'b1;
                    w_filt_nxt  = '0;
                    w_state_nxt = S_IDLE;
                end else if (r_filt + 4'd1 == c_FILTER) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_ACTIVE;
                end else begin
                    w_filt_nxt  = r_filt + 4'd1;
                end
            end
            S_ACTIVE: begin
                // Hold here for the remainder of the I/O cycle so a long
                // cycle yields only one strobe.
                if (w_iorq_s) begin
                    w_filt_nxt  = '0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_filt_nxt  = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered strobes, write-data capture and glitch counter. When
    // lock is set the access is still tracked by the FSM but produces
    // no visible effect.
    // ------------------------------------------------------------------
    logic       w_fire;
    logic       r_page_up_stb;
    logic       r_io_rd_stb;
    logic       r_io_wr_stb;
    logic [7:0] r_wr_data;
    logic [7:0] r_glitch_cnt;

    assign w_fire = w_accept && !lock;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_page_up_stb <= 1'b0;
            r_io_rd_stb   <= 1'b0;
            r_io_wr_stb   <= 1'b0;
            r_wr_data     <= '0;
            r_glitch_cnt  <= '0;
        end else begin
            r_page_up_stb <= w_fire;
            // RD and WR both low counts as a write.
            r_io_wr_stb   <= w_fire && !w_wr_s;
            r_io_rd_stb   <= w_fire &&  w_wr_s;
            if (w_fire && !w_wr_s) begin
                r_wr_data <= w_d_s;
            end
            if (w_glitch && (r_glitch_cnt != 8'hFF)) begin
                r_glitch_cnt <= r_glitch_cnt + 8'd1;
            end
        end
    end

    assign page_up_stb = r_page_up_stb;
    assign io_rd_stb   = r_io_rd_stb;
    assign io_wr_stb   = r_io_wr_stb;
    assign wr_data     = r_wr_data;
    assign glitch_cnt  = r_glitch_cnt;
    assign busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire
